fp_to_int_pipe: RTL and testbench
=================================

Name: fp_to_int_pipe

Overview:
- Pipelined IEEE-754 single-precision to signed-integer converter for the FPU `cvt.w.s` / `trunc` / `round` / `ceil` / `floor` paths.
- Generalised in integer width and rounding mode, with full NaN/Inf/denormal handling and exact inexact and invalid flags.
- Three-stage pipeline with valid/ready handshake on both sides.
- Sits between the FP register-read stage and FPU writeback; a tag is carried through for the destination register.

Parameters:
- INT_W, 32, integer result width; legal values 32 or 64.
- TAG_W, 5, width of the pass-through tag (destination register index).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline kill; drops all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  converter accepts the input this cycle.
- in_num  in  32  single-precision operand.
- in_rm  in  2  rounding mode: 0 = RN (nearest-even), 1 = RZ, 2 = RP (+inf), 3 = RM (-inf).
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  INT_W  two's-complement integer.
- out_invalid  out  1  NaN, Inf, or out-of-range operand.
- out_inexact  out  1  discarded fraction was nonzero.
- out_tag  out  TAG_W  tag of the reported result.

Behaviour:
- Reset: all stage valid bits, out_valid, out_result, out_invalid, out_inexact and out_tag are 0.
- Flush: clears every stage valid bit in the same cycle, including the output stage; a handshake that coincides with flush is not counted.
- Advance condition: adv = !(out_valid && !out_ready).
  - When adv is 1, all stages shift forward.
  - When adv is 0, every stage holds its contents.
  - in_ready = adv, combinationally; bubbles are not squeezed.
- Latency: 3 cycles from an accepted input to out_valid with no backpressure. Throughput is 1 per cycle. Results leave in order.
- S1, unpack/classify:
  - sign = num[31]; e = num[30:23] - 127, signed 9-bit.
  - sig = {|num[30:23], num[22:0]}, 24 bits; denormals have hidden bit 0, and with e = -127 they round as tiny values.
  - Class is NaN (exp all ones, frac ≠ 0), Inf (exp all ones, frac = 0), Zero, or Finite.
- S2, align:
  - Compute integer magnitude mag (INT_W+1 bits), guard bit G (first bit below the binary point) and sticky S (OR of all lower bits).
  - e ≥ INT_W: set the range-overflow flag; mag is don't-care.
  - 23 ≤ e < INT_W: mag = sig << (e-23); G = S = 0.
  - 0 ≤ e < 23: mag = sig >> (23-e); G = sig[22-e]; S = OR of the bits below G.
  - e = -1: mag = 0, G = sig[23], S = |sig[22:0].
  - e < -1: mag = 0, G = 0, S = |sig.
- S3, round/range/sign:
  - Increment inc by mode:
    - RN: G && (S || mag[0]).
    - RZ: 0.
    - RP: !sign && (G || S).
    - RM: sign && (G || S).
  - m2 = mag + inc.
  - Invalid when any of these holds: NaN; Inf; range overflow; !sign && m2 > 2^(INT_W-1)-1; sign && m2 > 2^(INT_W-1).
  - If invalid: result = 2^(INT_W-1)-1 regardless of sign, invalid = 1, inexact = 0.
  - Otherwise: result = sign ? -m2 : m2, and inexact = G || S.
- Zero handling: -0.0 gives 0, exact. -2^(INT_W-1) exactly is valid and exact.

Decomposition:
- Shared package fp_pkg:
  - Rounding-mode constants RM_RN, RM_RZ, RM_RP, RM_RM.
  - Single-precision field widths and bias: EXP_W = 8, MAN_W = 23, BIAS = 127.
  - Class enum FP_ZERO, FP_FINITE, FP_INF, FP_NAN.
- One sub-module, fp_unpack: combinational S1 classify/unpack, reusable by other FPU converters.

Test Plan:
- RN/RZ/RP/RM on 2.5 (0x40200000) → 2, 2, 3, 2, all inexact. On -2.5 (0xC0200000) → -2, -2, -2, -3, all inexact. On 3.5 RN → 4.
- INT_W=32:
  - 0x4F000000 (2^31) → 0x7FFFFFFF invalid.
  - 0xCF000000 (-2^31) → 0x80000000, valid and exact.
  - 0x7FC00000 NaN and 0xFF800000 -Inf → 0x7FFFFFFF invalid.
- Tiny values:
  - 0x3F000000 (0.5): RN → 0 inexact; RP → 1 inexact.
  - Denormal 0x00000001: RM → 0; with sign bit set, RM → -1 (0xFFFFFFFF), inexact.
- Backpressure:
  - Stream 6 back-to-back inputs, tags 0–5, with out_ready low for cycles 4–8.
  - in_ready drops as soon as the head result stalls; all 6 results arrive in tag order with no loss or duplication.
- Flush and reset:
  - Assert flush with 3 ops in flight → no out_valid for them; the next accepted input appears exactly 3 cycles later.
  - Assert rst mid-stream → all outputs 0 the following cycle.
- INT_W=64: 0x53800000 (2^40) → 0x0000010000000000 exact; 0x5F000000 (2^63) → 0x7FFFFFFFFFFFFFFF invalid.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp_pkg
// Purpose: Shared definitions for the FPU conversion datapaths: IEEE-754
//          single-precision field layout, rounding-mode encodings and the
//          operand class enumeration.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package fp_pkg;

  // Single-precision field layout
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  // Rounding-mode encodings as carried on the rm inputs
  localparam logic [1:0] RM_RN = 2'd0;  // nearest, ties to even
  localparam logic [1:0] RM_RZ = 2'd1;  // toward zero
  localparam logic [1:0] RM_RP = 2'd2;  // toward +inf
  localparam logic [1:0] RM_RM = 2'd3;  // toward -inf

  typedef enum logic [1:0] {
    FP_ZERO   = 2'd0,
    FP_FINITE = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_e;

endpackage
`default_nettype wire

// File: rtl/fp_unpack.sv
`default_nettype none
// ============================================================================
// Module : fp_unpack
// Purpose: Combinational unpack/classify of a single-precision operand.
//          Produces sign, unbiased exponent and significand with the hidden
//          bit made explicit. Denormals keep hidden bit 0 and report an
//          exponent of -127, so downstream logic treats them as tiny values.
// Ports  : num_i   in  32        single-precision operand
//          sign_o  out 1         sign bit
//          exp_o   out EXP_W+1   unbiased exponent, two's complement
//          sig_o   out MAN_W+1   significand {hidden, fraction}
//          cls_o   out 2         fp_class_e encoding
// Rev    : 1.0  initial release
// ============================================================================
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]               num_i,
  output logic                      sign_o,
  output logic signed [EXP_W:0]     exp_o,
  output logic [MAN_W:0]            sig_o,
  output logic [1:0]                cls_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac_f;
  logic             exp_ones;
  logic             exp_zero;
  logic             frac_nz;

  assign exp_f    = num_i[30:23];
  assign frac_f   = num_i[22:0];
  assign exp_ones = &exp_f;
  assign exp_zero = ~|exp_f;
  assign frac_nz  = |frac_f;

  assign sign_o = num_i[31];
  assign exp_o  = $signed({1'b0, exp_f} - (EXP_W + 1)'(BIAS));
  assign sig_o  = {~exp_zero, frac_f};

  always_comb begin
    cls_o = FP_FINITE;
    if (exp_ones) begin
      cls_o = frac_nz ? FP_NAN : FP_INF;
    end else if (exp_zero && !frac_nz) begin
      cls_o = FP_ZERO;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_to_int_pipe.sv
`default_nettype none
// ============================================================================
// Module : fp_to_int_pipe
// Purpose: Three-stage single-precision to signed-integer converter with
//          selectable rounding mode, saturating invalid handling and exact
//          inexact/invalid flags. valid/ready on both sides; tag passes
//          through unchanged.
//            S1  unpack/classify (registered operand fields)
//            S2  align to integer magnitude + guard/sticky
//            S3  round, range check, apply sign (output registers)
// Ports  : clk, rst            clock, synchronous active-high reset
//          flush               kill all in-flight operations
//          in_valid/in_ready   input handshake (in_ready = pipeline advance)
//          in_num/in_rm/in_tag operand, rounding mode, tag
//          out_valid/out_ready output handshake
//          out_result          INT_W-bit two's-complement result
//          out_invalid         NaN, Inf or out-of-range operand
//          out_inexact         discarded fraction nonzero
//          out_tag             tag of the reported result
// Params : INT_W  integer width, 32 or 64
//          TAG_W  tag width
// Rev    : 1.0  initial release
// ============================================================================
module fp_to_int_pipe
  import fp_pkg::*;
#(
  parameter int INT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_num,
  input  logic [1:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_result,
  output logic             out_invalid,
  output logic             out_inexact,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int WIDE_W = 2 * SIG_W;
  localparam int MAG_W  = INT_W + 1;

  // Magnitude limits after rounding, and the saturated invalid result
  localparam logic [MAG_W-1:0] MAX_POS = {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [MAG_W-1:0] MAX_NEG = {2'b01, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] SAT_VAL = {1'b0, {(INT_W-1){1'b1}}};

  // --------------------------------------------------------------------------
  // Flow control: the whole pipe moves together unless the output is stalled
  // --------------------------------------------------------------------------
  logic adv;
  logic out_valid_q;

  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;

  // --------------------------------------------------------------------------
  // S1: unpack
  // --------------------------------------------------------------------------
  logic                  u_sign;
  logic signed [EXP_W:0] u_exp;
  logic [MAN_W:0]        u_sig;
  logic [1:0]            u_cls;

  fp_unpack u_unpack (
    .num_i  (in_num),
    .sign_o (u_sign),
    .exp_o  (u_exp),
    .sig_o  (u_sig),
    .cls_o  (u_cls)
  );

  logic                  s1_valid_q;
  logic                  s1_sign_q;
  logic signed [EXP_W:0] s1_exp_q;
  logic [SIG_W-1:0]      s1_sig_q;
  logic [1:0]            s1_cls_q;
  logic [1:0]            s1_rm_q;
  logic [TAG_W-1:0]      s1_tag_q;

  // --------------------------------------------------------------------------
  // S2: align
  // --------------------------------------------------------------------------
  logic signed [31:0] e_v;
  logic [WIDE_W-1:0]  wide;
  logic [WIDE_W-1:0]  shifted;
  logic [MAG_W-1:0]   s2_mag_d;
  logic               s2_g_d;
  logic               s2_s_d;
  logic               s2_inv_d;

  always_comb begin
    e_v      = {{(32-EXP_W-1){s1_exp_q[EXP_W]}}, s1_exp_q};
    // Significand sits in the upper half; the lower half catches the bits
    // shifted out below the binary point (guard + sticky).
    wide     = {s1_sig_q, {SIG_W{1'b0}}};
    shifted  = '0;
    s2_mag_d = '0;
    s2_g_d   = 1'b0;
    s2_s_d   = 1'b0;
    s2_inv_d = (s1_cls_q == FP_NAN) || (s1_cls_q == FP_INF);

    if (e_v >= INT_W) begin
      s2_inv_d = 1'b1;
    end else if (e_v >= 23) begin
      s2_mag_d = MAG_W'(s1_sig_q) << (e_v - 23);
    end else if (e_v >= -1) begin
      // Right shift by 1..24; e = -1 leaves the whole significand as fraction
      shifted  = wide >> (23 - e_v);
      s2_mag_d = MAG_W'(shifted[WIDE_W-1:SIG_W]);
      s2_g_d   = shifted[SIG_W-1];
      s2_s_d   = |shifted[SIG_W-2:0];
    end else begin
      s2_s_d   = |s1_sig_q;
    end
  end

  logic               s2_valid_q;
  logic               s2_sign_q;
  logic [1:0]         s2_rm_q;
  logic [TAG_W-1:0]   s2_tag_q;
  logic [MAG_W-1:0]   s2_mag_q;
  logic               s2_g_q;
  logic               s2_s_q;
  logic               s2_inv_q;

  // --------------------------------------------------------------------------
  // S3: round, range check, sign
  // --------------------------------------------------------------------------
  logic               inc;
  logic [MAG_W-1:0]   m2;
  logic [INT_W-1:0]   m2_lo;
  logic               too_big;
  logic [INT_W-1:0]   res_d;
  logic               inv_d;
  logic               inx_d;

  always_comb begin
    case (s2_rm_q)
      RM_RN:   inc = s2_g_q && (s2_s_q || s2_mag_q[0]);
      RM_RZ:   inc = 1'b0;
      RM_RP:   inc = !s2_sign_q && (s2_g_q || s2_s_q);
      default: inc = s2_sign_q && (s2_g_q || s2_s_q);
    endcase

    // mag < 2^INT_W whenever it is meaningful, so +1 cannot wrap MAG_W bits
    m2      = s2_mag_q + MAG_W'(inc);
    m2_lo   = m2[INT_W-1:0];
    // Negative side admits one extra magnitude: -2^(INT_W-1)
    too_big = s2_sign_q ? (m2 > MAX_NEG) : (m2 > MAX_POS);

    if (s2_inv_q || too_big) begin
      res_d = SAT_VAL;
      inv_d = 1'b1;
      inx_d = 1'b0;
    end else begin
      res_d = s2_sign_q ? -m2_lo : m2_lo;
      inv_d = 1'b0;
      inx_d = s2_g_q || s2_s_q;
    end
  end

  logic [INT_W-1:0] out_result_q;
  logic             out_invalid_q;
  logic             out_inexact_q;
  logic [TAG_W-1:0] out_tag_q;

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_sig_q      <= '0;
      s1_cls_q      <= '0;
      s1_rm_q       <= '0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_rm_q       <= '0;
      s2_tag_q      <= '0;
      s2_mag_q      <= '0;
      s2_g_q        <= 1'b0;
      s2_s_q        <= 1'b0;
      s2_inv_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_invalid_q <= 1'b0;
      out_inexact_q <= 1'b0;
      out_tag_q     <= '0;
    end else begin
      // Valid bits: flush wins over any handshake in the same cycle
      if (flush) begin
        s1_valid_q  <= 1'b0;
        s2_valid_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else if (adv) begin
        s1_valid_q  <= in_valid;
        s2_valid_q  <= s1_valid_q;
        out_valid_q <= s2_valid_q;
      end

      // Payload moves with adv; stale payload behind a cleared valid is inert
      if (adv) begin
        s1_sign_q     <= u_sign;
        s1_exp_q      <= u_exp;
        s1_sig_q      <= u_sig;
        s1_cls_q      <= u_cls;
        s1_rm_q       <= in_rm;
        s1_tag_q      <= in_tag;
        s2_sign_q     <= s1_sign_q;
        s2_rm_q       <= s1_rm_q;
        s2_tag_q      <= s1_tag_q;
        s2_mag_q      <= s2_mag_d;
        s2_g_q        <= s2_g_d;
        s2_s_q        <= s2_s_d;
        s2_inv_q      <= s2_inv_d;
        out_result_q  <= res_d;
        out_invalid_q <= inv_d;
        out_inexact_q <= inx_d;
        out_tag_q     <= s2_tag_q;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_invalid = out_invalid_q;
  assign out_inexact = out_inexact_q;
  assign out_tag     = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_fp_to_int_pipe
// Purpose: Directed self-checking bench for fp_to_int_pipe. A 32-bit and a
//          64-bit instance share the same stimulus and run in lockstep.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fp_to_int_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_num;
  logic [1:0]  in_rm;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        r32_in_ready;
  logic        r32_out_valid;
  logic [31:0] r32_out_result;
  logic        r32_out_invalid;
  logic        r32_out_inexact;
  logic [4:0]  r32_out_tag;

  logic        r64_in_ready;
  logic        r64_out_valid;
  logic [63:0] r64_out_result;
  logic        r64_out_invalid;
  logic        r64_out_inexact;
  logic [4:0]  r64_out_tag;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] tag_cnt = 5'd0;

  fp_to_int_pipe #(.INT_W(32), .TAG_W(5)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (r32_in_ready),
    .in_num      (in_num),
    .in_rm       (in_rm),
    .in_tag      (in_tag),
    .out_valid   (r32_out_valid),
    .out_ready   (out_ready),
    .out_result  (r32_out_result),
    .out_invalid (r32_out_invalid),
    .out_inexact (r32_out_inexact),
    .out_tag     (r32_out_tag)
  );

  fp_to_int_pipe #(.INT_W(64), .TAG_W(5)) dut64 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (r64_in_ready),
    .in_num      (in_num),
    .in_rm       (in_rm),
    .in_tag      (in_tag),
    .out_valid   (r64_out_valid),
    .out_ready   (out_ready),
    .out_result  (r64_out_result),
    .out_invalid (r64_out_invalid),
    .out_inexact (r64_out_inexact),
    .out_tag     (r64_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small integers 1.0 .. 6.0 as single precision
  logic [31:0] int_tbl [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated conversion, no backpressure; waits a bounded time for output
  task automatic run_op(input string name, input logic [31:0] num, input logic [1:0] rm,
                        input bit is64, input logic [63:0] exp_res,
                        input bit exp_inv, input bit exp_inx);
    int  n;
    bit  got;
    logic [4:0] t;
    t = tag_cnt;
    tag_cnt = tag_cnt + 5'd1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_num = num; in_rm = rm; in_tag = t; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 8) begin
      if (is64 ? r64_out_valid : r32_out_valid) got = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
    check_eq({name, "_valid"}, 64'(got), 64'd1);
    if (got) begin
      if (is64) begin
        check_eq({name, "_res"}, r64_out_result, exp_res);
        check_eq({name, "_inv"}, 64'(r64_out_invalid), 64'(exp_inv));
        check_eq({name, "_inx"}, 64'(r64_out_inexact), 64'(exp_inx));
        check_eq({name, "_tag"}, 64'(r64_out_tag), 64'(t));
      end else begin
        check_eq({name, "_res"}, 64'(r32_out_result), exp_res);
        check_eq({name, "_inv"}, 64'(r32_out_invalid), 64'(exp_inv));
        check_eq({name, "_inx"}, 64'(r32_out_inexact), 64'(exp_inx));
        check_eq({name, "_tag"}, 64'(r32_out_tag), 64'(t));
      end
    end
  endtask

  task automatic backpressure_test();
    int sent;
    int rcvd;
    sent = 0;
    rcvd = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      if (sent < 6) begin
        in_valid = 1'b1; in_num = int_tbl[sent]; in_rm = 2'd1; in_tag = 5'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 4) check_eq("bp_in_ready_stall", 64'(r32_in_ready), 64'd0);
      if (in_valid && r32_in_ready) sent++;
      if (r32_out_valid && out_ready) begin
        check_eq("bp_tag", 64'(r32_out_tag), 64'(rcvd));
        check_eq("bp_res", 64'(r32_out_result), 64'(rcvd + 1));
        rcvd++;
      end
      @(posedge clk); #1;
      if (rcvd == 6) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_count", 64'(rcvd), 64'd6);
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_no_dup", 64'(r32_out_valid), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic flush_test();
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_num = int_tbl[0]; in_rm = 2'd0; in_tag = 5'd20;
    @(posedge clk); #1;
    in_num = int_tbl[1]; in_tag = 5'd21;
    @(posedge clk); #1;
    in_num = int_tbl[2]; in_tag = 5'd22; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_num = 32'h40E00000; in_tag = 5'd9;  // 7.0
    check_eq("flush_quiet0", 64'(r32_out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("flush_quiet1", 64'(r32_out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("flush_quiet2", 64'(r32_out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("flush_next_valid", 64'(r32_out_valid), 64'd1);
    check_eq("flush_next_tag", 64'(r32_out_tag), 64'd9);
    check_eq("flush_next_res", 64'(r32_out_result), 64'd7);
  endtask

  task automatic reset_test();
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_num = 32'hC0200000; in_rm = 2'd3; in_tag = 5'd17;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_pre_valid", 64'(r32_out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("rst_valid", 64'(r32_out_valid), 64'd0);
    check_eq("rst_res", 64'(r32_out_result), 64'd0);
    check_eq("rst_inv", 64'(r32_out_invalid), 64'd0);
    check_eq("rst_inx", 64'(r32_out_inexact), 64'd0);
    check_eq("rst_tag", 64'(r32_out_tag), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_after_valid", 64'(r32_out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_num = '0; in_rm = '0;
    in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_valid", 64'(r32_out_valid), 64'd0);
    check_eq("reset_res", 64'(r32_out_result), 64'd0);
    check_eq("reset_inv", 64'(r32_out_invalid), 64'd0);
    check_eq("reset_inx", 64'(r32_out_inexact), 64'd0);
    check_eq("reset_tag", 64'(r32_out_tag), 64'd0);
    check_eq("reset_valid64", 64'(r64_out_valid), 64'd0);
    rst = 1'b0;

    // Rounding modes on +/-2.5 and 3.5
    run_op("p25_rn", 32'h40200000, 2'd0, 1'b0, 64'h2, 1'b0, 1'b1);
    run_op("p25_rz", 32'h40200000, 2'd1, 1'b0, 64'h2, 1'b0, 1'b1);
    run_op("p25_rp", 32'h40200000, 2'd2, 1'b0, 64'h3, 1'b0, 1'b1);
    run_op("p25_rm", 32'h40200000, 2'd3, 1'b0, 64'h2, 1'b0, 1'b1);
    run_op("n25_rn", 32'hC0200000, 2'd0, 1'b0, 64'hFFFFFFFE, 1'b0, 1'b1);
    run_op("n25_rz", 32'hC0200000, 2'd1, 1'b0, 64'hFFFFFFFE, 1'b0, 1'b1);
    run_op("n25_rp", 32'hC0200000, 2'd2, 1'b0, 64'hFFFFFFFE, 1'b0, 1'b1);
    run_op("n25_rm", 32'hC0200000, 2'd3, 1'b0, 64'hFFFFFFFD, 1'b0, 1'b1);
    run_op("p35_rn", 32'h40600000, 2'd0, 1'b0, 64'h4, 1'b0, 1'b1);

    // Range boundaries and specials
    run_op("p2e31", 32'h4F000000, 2'd0, 1'b0, 64'h7FFFFFFF, 1'b1, 1'b0);
    run_op("n2e31", 32'hCF000000, 2'd1, 1'b0, 64'h80000000, 1'b0, 1'b0);
    run_op("nan", 32'h7FC00000, 2'd0, 1'b0, 64'h7FFFFFFF, 1'b1, 1'b0);
    run_op("ninf", 32'hFF800000, 2'd0, 1'b0, 64'h7FFFFFFF, 1'b1, 1'b0);
    run_op("nzero", 32'h80000000, 2'd3, 1'b0, 64'h0, 1'b0, 1'b0);

    // Tiny values
    run_op("half_rn", 32'h3F000000, 2'd0, 1'b0, 64'h0, 1'b0, 1'b1);
    run_op("half_rp", 32'h3F000000, 2'd2, 1'b0, 64'h1, 1'b0, 1'b1);
    run_op("pden_rm", 32'h00000001, 2'd3, 1'b0, 64'h0, 1'b0, 1'b1);
    run_op("nden_rm", 32'h80000001, 2'd3, 1'b0, 64'hFFFFFFFF, 1'b0, 1'b1);

    // 64-bit instance
    run_op("w64_2e40", 32'h53800000, 2'd0, 1'b1, 64'h0000010000000000, 1'b0, 1'b0);
    run_op("w64_2e63", 32'h5F000000, 2'd0, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0);
    run_op("w64_n2e63", 32'hDF000000, 2'd1, 1'b1, 64'h8000000000000000, 1'b0, 1'b0);
    run_op("w64_2e31", 32'h4F000000, 2'd0, 1'b1, 64'h0000000080000000, 1'b0, 1'b0);

    backpressure_test();
    flush_test();
    reset_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
